// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the matrix multiplier control path.
package matrix_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] ST_LOAD     = 3'd0;
    localparam logic [2:0] ST_GAP      = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_RES = 3'd3;
    localparam logic [2:0] ST_EMIT     = 3'd4;

    typedef enum logic [2:0] {
        LOAD     = ST_LOAD,
        GAP      = ST_GAP,
        ISSUE    = ST_ISSUE,
        WAIT_RES = ST_WAIT_RES,
        EMIT     = ST_EMIT
    } state_t;

    localparam logic [WORD_WIDTH-1:0] FP_ONE = 32'h3F800000;

endpackage

// File: rtl/operand_store.sv
// Holds matrices A and B; serial write port, combinational row-i / column-j read.
// MATRIX_FEEDER_B_COLMAJOR_EN: B load words are placed column-major.
module operand_store
    import matrix_pkg::*;
#(
    parameter int number_of_elements = 4,
    localparam int IW = $clog2(number_of_elements)
) (
    input  logic                                       clk,
    input  logic                                       wr_en,
    input  logic                                       wr_b,
    input  logic [IW-1:0]                              wr_row,
    input  logic [IW-1:0]                              wr_col,
    input  logic [WORD_WIDTH-1:0]                      wr_data,
    input  logic [IW-1:0]                              rd_row,
    input  logic [IW-1:0]                              rd_col,
    output logic [WORD_WIDTH*number_of_elements-1:0]   row,
    output logic [WORD_WIDTH*number_of_elements-1:0]   column
);

    localparam int N = number_of_elements;

    logic [WORD_WIDTH-1:0] a_mem [N][N];
    logic [WORD_WIDTH-1:0] b_mem [N][N];

    // Storage is deliberately not reset; contents are rewritten on every load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_b) begin
                a_mem[wr_row][wr_col] <= wr_data;
            end else begin
`ifdef MATRIX_FEEDER_B_COLMAJOR_EN
                b_mem[wr_col][wr_row] <= wr_data;
`else
                b_mem[wr_row][wr_col] <= wr_data;
`endif
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_read
        assign row[WORD_WIDTH*k +: WORD_WIDTH]    = a_mem[rd_row][k];
        assign column[WORD_WIDTH*k +: WORD_WIDTH] = b_mem[k][rd_col];
    end

endmodule

// File: rtl/matrix_operand_feeder.sv
// Control path of the matrix multiplier: loads A/B, feeds inner_product per (i,j), emits C row-major.
// MATRIX_FEEDER_B_COLMAJOR_EN selects column-major B loading (handled in operand_store).
module matrix_operand_feeder
    import matrix_pkg::*;
#(
    parameter int number_of_elements = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [WORD_WIDTH-1:0]                      load_i_data,
    input  logic                                       load_i_stb,
    output logic                                       load_i_ack,
    output logic [WORD_WIDTH*number_of_elements-1:0]   row,
    output logic [WORD_WIDTH*number_of_elements-1:0]   column,
    output logic                                       row_o_stb,
    output logic                                       column_o_stb,
    output logic                                       prod_o_ack,
    input  logic                                       row_i_ack,
    input  logic                                       column_i_ack,
    input  logic [WORD_WIDTH-1:0]                      prod,
    input  logic                                       prod_i_stb,
    output logic [WORD_WIDTH-1:0]                      res_o_data,
    output logic                                       res_o_stb,
    input  logic                                       res_i_ack,
    output logic                                       res_o_last,
    output logic                                       busy
);

    localparam int N  = number_of_elements;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] ld_row;
    logic [IW-1:0] ld_col;
    logic          ld_b;
    logic [IW-1:0] i_idx;
    logic [IW-1:0] j_idx;
    logic          gap_cnt;
    logic          row_seen;
    logic          col_seen;
    logic          seen_low;

    logic load_fire;
    logic load_last;
    logic both_acked;
    logic capture;
    logic last_elem;

    assign load_fire  = load_i_stb & load_i_ack;
    assign load_last  = ld_b & (ld_row == LAST_IDX) & (ld_col == LAST_IDX);
    assign both_acked = (row_seen | row_i_ack) & (col_seen | column_i_ack);
    // Only a rising result after a low sample counts, so a stale strobe is ignored.
    assign capture    = prod_i_stb & seen_low;
    assign last_elem  = (i_idx == LAST_IDX) & (j_idx == LAST_IDX);

    operand_store #(
        .number_of_elements(N)
    ) u_store (
        .clk    (clk),
        .wr_en  (load_fire),
        .wr_b   (ld_b),
        .wr_row (ld_row),
        .wr_col (ld_col),
        .wr_data(load_i_data),
        .rd_row (i_idx),
        .rd_col (j_idx),
        .row    (row),
        .column (column)
    );

    always_comb begin
        state_next   = state;
        load_i_ack   = 1'b0;
        row_o_stb    = 1'b0;
        column_o_stb = 1'b0;
        prod_o_ack   = 1'b0;
        res_o_stb    = 1'b0;
        res_o_last   = 1'b0;
        busy         = (state != LOAD);
        case (state)
            LOAD: begin
                load_i_ack = 1'b1;
                if (load_i_stb && load_last) state_next = GAP;
            end
            GAP: begin
                if (gap_cnt) state_next = ISSUE;
            end
            ISSUE: begin
                row_o_stb    = 1'b1;
                column_o_stb = 1'b1;
                prod_o_ack   = 1'b1;
                if (both_acked) state_next = WAIT_RES;
            end
            WAIT_RES: begin
                if (capture) state_next = EMIT;
            end
            EMIT: begin
                res_o_stb  = 1'b1;
                res_o_last = last_elem;
                if (res_i_ack) state_next = last_elem ? LOAD : GAP;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            ld_row     <= '0;
            ld_col     <= '0;
            ld_b       <= 1'b0;
            i_idx      <= '0;
            j_idx      <= '0;
            gap_cnt    <= 1'b0;
            row_seen   <= 1'b0;
            col_seen   <= 1'b0;
            seen_low   <= 1'b0;
            res_o_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        if (ld_col == LAST_IDX) begin
                            ld_col <= '0;
                            if (ld_row == LAST_IDX) begin
                                ld_row <= '0;
                                ld_b   <= ~ld_b;
                            end else begin
                                ld_row <= ld_row + 1'b1;
                            end
                        end else begin
                            ld_col <= ld_col + 1'b1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt  <= ~gap_cnt;
                    row_seen <= 1'b0;
                    col_seen <= 1'b0;
                    seen_low <= 1'b0;
                end
                ISSUE: begin
                    row_seen <= row_seen | row_i_ack;
                    col_seen <= col_seen | column_i_ack;
                end
                WAIT_RES: begin
                    if (!prod_i_stb) seen_low <= 1'b1;
                    if (capture) res_o_data <= prod;
                end
                EMIT: begin
                    if (res_i_ack) begin
                        if (j_idx == LAST_IDX) begin
                            j_idx <= '0;
                            i_idx <= (i_idx == LAST_IDX) ? '0 : i_idx + 1'b1;
                        end else begin
                            j_idx <= j_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Randomized bench for matrix_operand_feeder with a behavioural inner_product engine and result model.
module tb_matrix_operand_feeder;
    import matrix_pkg::*;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     load_i_data;
    logic            load_i_stb;
    logic            load_i_ack;
    logic [32*N-1:0] row;
    logic [32*N-1:0] column;
    logic            row_o_stb;
    logic            column_o_stb;
    logic            prod_o_ack;
    logic            row_i_ack;
    logic            column_i_ack;
    logic [31:0]     prod;
    logic            prod_i_stb;
    logic [31:0]     res_o_data;
    logic            res_o_stb;
    logic            res_i_ack;
    logic            res_o_last;
    logic            busy;

    matrix_operand_feeder #(.number_of_elements(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_i_data (load_i_data),
        .load_i_stb  (load_i_stb),
        .load_i_ack  (load_i_ack),
        .row         (row),
        .column      (column),
        .row_o_stb   (row_o_stb),
        .column_o_stb(column_o_stb),
        .prod_o_ack  (prod_o_ack),
        .row_i_ack   (row_i_ack),
        .column_i_ack(column_i_ack),
        .prod        (prod),
        .prod_i_stb  (prod_i_stb),
        .res_o_data  (res_o_data),
        .res_o_stb   (res_o_stb),
        .res_i_ack   (res_i_ack),
        .res_o_last  (res_o_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [N][N];
    logic [31:0] mb [N][N];
    logic [31:0] words [2*NN];
    logic [31:0] exp_q [$];
    logic [31:0] got [NN];
    int res_idx   = 0;
    int issue_idx = 0;

    int  eph = 0;
    int  ecnt, erd, ecd, elow;
    logic [31:0] eres;
    bit  skew_fixed = 1'b0;
    bit  rand_ack   = 1'b0;
    bit  bp_armed   = 1'b0;
    int  bp_index   = 0;
    int  hold       = 0;

    localparam logic [31:0] RAMP [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine arithmetic: 1.0 passes the other operand through, 0 gives 0, otherwise integer product.
    function automatic logic [31:0] mul_el(input logic [31:0] a, input logic [31:0] b);
        if (a == FP_ONE) return b;
        if (a == 32'h0) return 32'h0;
        return a * b;
    endfunction

    function automatic logic [31:0] model_c(input int i, input int j);
        logic [31:0] s = 32'h0;
        for (int k = 0; k < N; k++) s += mul_el(ma[i][k], mb[k][j]);
        return s;
    endfunction

    // Behavioural inner_product plus result consumer, stepped just after each rising edge.
    initial begin
        row_i_ack = 1'b0; column_i_ack = 1'b0; res_i_ack = 1'b0;
        prod = 32'h0; prod_i_stb = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rst !== 1'b1) begin
                eph = 0; hold = 0;
                row_i_ack = 1'b0; column_i_ack = 1'b0; prod_i_stb = 1'b0; res_i_ack = 1'b0;
            end else begin
                if (eph == 2) begin
                    row_i_ack = 1'b0; column_i_ack = 1'b0; prod_i_stb = 1'b0;
                    elow--;
                    if (elow == 0) eph = 3;
                end else if (eph == 3) begin
                    prod_i_stb = 1'b1; prod = eres; eph = 0;
                end else begin
                    if (eph == 0 && row_o_stb && column_o_stb && prod_o_ack) begin
                        eres = 32'h0;
                        for (int k = 0; k < N; k++)
                            eres += mul_el(row[32*k +: 32], column[32*k +: 32]);
                        ecnt = 0;
                        erd  = skew_fixed ? 0 : int'($urandom_range(0, 4));
                        ecd  = skew_fixed ? 3 : int'($urandom_range(0, 4));
                        eph  = 1;
                    end
                    if (eph == 1) begin
                        row_i_ack    = (ecnt == erd);
                        column_i_ack = (ecnt == ecd);
                        if (ecnt == ((erd > ecd) ? erd : ecd)) begin
                            eph  = 2;
                            elow = skew_fixed ? 1 : int'($urandom_range(1, 3));
                        end
                        ecnt++;
                    end else begin
                        row_i_ack = 1'b0; column_i_ack = 1'b0;
                    end
                end
                if (hold > 0) begin
                    res_i_ack = 1'b0; hold--;
                end else if (res_o_stb && bp_armed && res_idx == bp_index) begin
                    res_i_ack = 1'b0; hold = 9; bp_armed = 1'b0;
                end else begin
                    res_i_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model on every meaningful cycle.
    initial begin
        logic prev_row = 1'b0, prev_stb = 1'b0, prev_ack = 1'b0;
        logic seen_r = 1'b0, seen_c = 1'b0;
        logic [31:0] prev_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_row = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0;
                continue;
            end
            checkOutput("busy_vs_load_ack", {31'b0, busy}, {31'b0, ~load_i_ack});
            if (row_o_stb || column_o_stb || prod_o_ack)
                checkOutput("strobe_group", {29'b0, row_o_stb, column_o_stb, prod_o_ack}, 32'h7);
            if (row_o_stb && !prev_row) begin
                seen_r = 1'b0; seen_c = 1'b0;
                if (issue_idx >= NN) begin
                    checkOutput("issue_count", issue_idx, NN - 1);
                end else begin
                    for (int k = 0; k < N; k++) begin
                        checkOutput("issue_row", row[32*k +: 32], ma[issue_idx / N][k]);
                        checkOutput("issue_col", column[32*k +: 32], mb[k][issue_idx % N]);
                    end
                end
                issue_idx++;
            end
            if (row_o_stb) begin
                seen_r |= row_i_ack; seen_c |= column_i_ack;
            end
            if (prev_row && !row_o_stb)
                checkOutput("drop_after_acks", {30'b0, seen_r, seen_c}, 32'h3);
            if (prev_stb && !prev_ack) begin
                checkOutput("res_hold_stb", {31'b0, res_o_stb}, 32'h1);
                checkOutput("res_hold_data", res_o_data, prev_data);
            end
            if (res_o_stb) begin
                checkOutput("no_issue_in_emit", {31'b0, row_o_stb}, 32'h0);
                if (exp_q.size() == 0) begin
                    checkOutput("extra_result", res_o_data, 32'hFFFFFFFF);
                end else begin
                    checkOutput("res_data", res_o_data, exp_q[0]);
                    checkOutput("res_last", {31'b0, res_o_last}, {31'b0, res_idx == NN - 1});
                    if (res_i_ack) begin
                        if (res_idx < NN) got[res_idx] = res_o_data;
                        res_idx++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_row = row_o_stb; prev_stb = res_o_stb; prev_ack = res_i_ack; prev_data = res_o_data;
        end
    end

    task automatic clearModel();
        exp_q.delete();
        res_idx = 0;
        issue_idx = 0;
    endtask

    task automatic buildExpect();
        clearModel();
        for (int k = 0; k < NN; k++) begin
            words[k] = ma[k / N][k % N];
`ifdef MATRIX_FEEDER_B_COLMAJOR_EN
            words[NN + k] = mb[k % N][k / N];
`else
            words[NN + k] = mb[k / N][k % N];
`endif
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_q.push_back(model_c(i, j));
    endtask

    task automatic randomMatrices();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                case ($urandom_range(0, 3))
                    0:       ma[i][j] = 32'h0;
                    1:       ma[i][j] = FP_ONE;
                    default: ma[i][j] = $urandom;
                endcase
                mb[i][j] = $urandom;
            end
    endtask

    task automatic applyStimulus(input bit toggle);
        int accepted = 0;
        int cyc = 0;
        while (accepted < 2 * NN && cyc < 400) begin
            @(posedge clk); #1;
            load_i_stb  = toggle ? ~load_i_stb : 1'b1;
            load_i_data = words[accepted];
            if (load_i_stb && load_i_ack) accepted++;
            cyc++;
        end
        checkOutput("words_accepted", accepted, 2 * NN);
        @(posedge clk); #1;
        load_i_stb  = 1'b1;
        load_i_data = 32'hBADBAD00;
        checkOutput("extra_word_ack", {31'b0, load_i_ack}, 32'h0);
        @(posedge clk); #1;
        load_i_stb = 1'b0;
    endtask

    task automatic waitResults();
        int cyc = 0;
        while (res_idx < NN && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("result_count", res_idx, NN);
        checkOutput("issue_total", issue_idx, NN);
        @(posedge clk); #1;
        checkOutput("back_in_load", {31'b0, load_i_ack}, 32'h1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_load_ack"}, {31'b0, load_i_ack}, 32'h1);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, "_strobes"}, {28'b0, row_o_stb, column_o_stb, prod_o_ack, res_o_stb}, 32'h0);
        checkOutput({tag, "_last"}, {31'b0, res_o_last}, 32'h0);
        checkOutput({tag, "_res_data"}, res_o_data, 32'h0);
    endtask

    initial begin
        rst = 1'b0; load_i_stb = 1'b0; load_i_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;

        // Identity times ramp, with toggled loads, fixed ack skew, stale strobe and result backpressure.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? FP_ONE : 32'h0;
                mb[i][j] = RAMP[i * N + j];
            end
        buildExpect();
        checkOutput("model_c02", model_c(0, 2), 32'h40400000);
        @(posedge clk); #3;
        prod = 32'hDEADBEEF; prod_i_stb = 1'b1;
        skew_fixed = 1'b1; rand_ack = 1'b0; bp_index = 5; bp_armed = 1'b1;
        applyStimulus(1'b1);
        waitResults();
        checkOutput("ident_first", got[0], 32'h3F800000);
        checkOutput("ident_stale", got[2], 32'h40400000);
        checkOutput("ident_bp_elem", got[5], 32'h40C00000);
        checkOutput("ident_last", got[15], 32'h41800000);

        skew_fixed = 1'b0; rand_ack = 1'b1;
        for (int r = 0; r < 2; r++) begin
            randomMatrices();
            buildExpect();
            applyStimulus(1'(r));
            waitResults();
        end

        // Abort while waiting for a product, then reload from scratch.
        randomMatrices();
        buildExpect();
        applyStimulus(1'b0);
        begin
            int cyc = 0;
            while (eph != 2 && cyc < 500) begin
                @(posedge clk); #1;
                cyc++;
            end
            checkOutput("reach_wait_res", {31'b0, eph == 2}, 32'h1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checkResetState("midreset");
        clearModel();
        rst = 1'b1;
        randomMatrices();
        buildExpect();
        applyStimulus(1'b1);
        waitResults();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
